mse_acc: RTL
============

// Module: mse_acc
// PURPOSE
//  Downstream stage of mse_4. Accumulates the per-word squared-difference partial sums
//  (4 bands per word) over all words of one spectral vector and emits the vector's total
//  squared error, with its word count, through a valid/ready output for the MSE/min-search logic.
//  mse_4 has no backpressure, so this block must never stall its input.
// PARAMETERS
//  DATA_WIDTH_SUM  32  width of sum_in (partial sum from mse_4)
//  ACC_WIDTH       40  accumulator/result width; must be >= DATA_WIDTH_SUM
//  CNT_WIDTH       8   word counter width
// PORTS
//  clk         in   1               clock, rising edge
//  rst         in   1               synchronous reset, active-high
//  clear       in   1               abort in-progress vector; clear overflow flag
//  sum_valid   in   1               sum_in carries a valid partial sum this cycle
//  sum_in      in   DATA_WIDTH_SUM  partial sum from mse_4
//  sum_last    in   1               qualifies sum_valid: last word of the vector
//  acc_valid   out  1               result register holds an unconsumed result
//  acc_ready   in   1               consumer accepts the result when acc_valid && acc_ready
//  acc_out     out  ACC_WIDTH       total squared error of the vector
//  acc_words   out  CNT_WIDTH       number of words accumulated into acc_out
//  acc_sat     out  1               acc_out saturated during accumulation
//  overflow    out  1               sticky: a result was dropped due to backpressure
// BEHAVIOUR
//  Reset: all outputs 0, accumulator 0, word counter 0, both FSMs in the first listed state.
//  Accumulate FSM, states IDLE (no words yet) and ACCUM:
//   - sum_valid && !sum_last: acc <= acc + sum_in, cnt <= cnt+1, go to ACCUM.
//   - sum_valid && sum_last: result = acc + sum_in, words = cnt+1.
//     Result goes to the output stage. acc <= 0, cnt <= 0, go to IDLE.
//   - A one-word vector (sum_last on the first word) is legal.
//  Arithmetic: sum_in is zero-extended to ACC_WIDTH.
//   - On carry out of ACC_WIDTH, acc clamps to 2^ACC_WIDTH-1.
//   - A vector-local sat bit is set, cleared when the vector ends.
//   - Once saturated, acc stays at max for the rest of the vector.
//   - cnt saturates at 2^CNT_WIDTH-1.
//  Output FSM, states EMPTY and FULL:
//   - Latency: result registered; acc_valid=1 on the cycle after the sum_last beat.
//   - acc_out, acc_words and acc_sat stay stable while acc_valid && !acc_ready.
//   - New result while EMPTY, or while FULL with acc_ready=1: load it, stay or go FULL.
//     Back-to-back results each cycle are supported with acc_ready=1.
//   - New result while FULL with acc_ready=0: drop the new result, keep the old one,
//     set overflow=1 (sticky).
//   - FULL, acc_ready=1 and no new result: acc_valid <= 0. acc_out keeps its value.
//  clear (priority over sum_valid the same cycle; that input word is discarded):
//   - acc <= 0, cnt <= 0, sat <= 0, overflow <= 0, go to IDLE.
//   - The output register and acc_valid are unaffected.
//  rst has priority over everything. A reset mid-vector or while FULL discards all state.
// TESTING
//  1. Words 7,7,7,7, sum_last on the 4th, ready=1.
//     -> next cycle acc_valid=1, acc_out=28, acc_words=4, acc_sat=0.
//  2. Consecutive one-word vectors 5 then 9 with sum_last=1, ready=1.
//     -> acc_out=5 then 9 on consecutive cycles, acc_valid high for 2 cycles.
//  3. ready=0: vector {10} completes, then vector {20} completes.
//     -> acc_out stays 10, overflow=1.
//     Then ready=1 for one cycle -> acc_valid=0 the next cycle.
//  4. ACC_WIDTH=33, three words 0xFFFFFFFF, last on the 3rd.
//     -> acc_out=0x1_FFFFFFFF, acc_sat=1, acc_words=3.
//  5. Words 3,4, then clear, then word 6 with sum_last.
//     -> acc_out=6, acc_words=1. clear also clears overflow.
//  6. Assert rst while acc_valid=1 and mid-vector.
//     -> next cycle all outputs 0. Next vector {2} -> acc_out=2, acc_words=1.

Source files
------------

// File: rtl/mse_acc.sv
// Accumulates per-word squared-difference partial sums over one spectral vector and
// presents the vector total and word count through a single-entry valid/ready output.
module mse_acc #(
    parameter int DATA_WIDTH_SUM = 32,
    parameter int ACC_WIDTH      = 40,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      sum_valid,
    input  logic [DATA_WIDTH_SUM-1:0] sum_in,
    input  logic                      sum_last,
    output logic                      acc_valid,
    input  logic                      acc_ready,
    output logic [ACC_WIDTH-1:0]      acc_out,
    output logic [CNT_WIDTH-1:0]      acc_words,
    output logic                      acc_sat,
    output logic                      overflow
);

    typedef enum logic {IDLE, ACCUM} acc_state_t;
    typedef enum logic {EMPTY, FULL} out_state_t;

    // Returns {carry, value}; value clamps to all-ones when the add carries out.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH_SUM-1:0] b);
        logic [ACC_WIDTH:0] s;
        s = {1'b0, a} + {{(ACC_WIDTH + 1 - DATA_WIDTH_SUM){1'b0}}, b};
        if (s[ACC_WIDTH]) begin
            s = {1'b1, {ACC_WIDTH{1'b1}}};
        end
        return s;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    acc_state_t                acc_state_q, acc_state_d;
    out_state_t                out_state_q, out_state_d;
    logic [ACC_WIDTH-1:0]      acc_q, acc_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic                      sat_q, sat_d;
    logic [ACC_WIDTH-1:0]      res_q, res_d;
    logic [CNT_WIDTH-1:0]      words_q, words_d;
    logic                      res_sat_q, res_sat_d;
    logic                      overflow_q, overflow_d;

    logic [ACC_WIDTH-1:0]      base_acc;
    logic [CNT_WIDTH-1:0]      base_cnt;
    logic                      base_sat;
    logic [ACC_WIDTH-1:0]      add_sum;
    logic                      add_carry;
    logic [CNT_WIDTH-1:0]      word_cnt;
    logic                      word_sat;
    logic                      new_result;
    logic                      load;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_state_q <= IDLE;
            out_state_q <= EMPTY;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            res_q       <= '0;
            words_q     <= '0;
            res_sat_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            acc_state_q <= acc_state_d;
            out_state_q <= out_state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            res_q       <= res_d;
            words_q     <= words_d;
            res_sat_q   <= res_sat_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        acc_state_d = acc_state_q;
        if (clear) begin
            acc_state_d = IDLE;
        end else if (sum_valid) begin
            acc_state_d = sum_last ? IDLE : ACCUM;
        end
    end

    // A vector always starts from a zero base, whatever the registers hold.
    always_comb begin
        base_acc = '0;
        base_cnt = '0;
        base_sat = 1'b0;
        if (acc_state_q == ACCUM) begin
            base_acc = acc_q;
            base_cnt = cnt_q;
            base_sat = sat_q;
        end
    end

    always_comb begin
        {add_carry, add_sum} = sat_add(base_acc, sum_in);
        word_cnt   = cnt_inc(base_cnt);
        word_sat   = base_sat | add_carry;
        new_result = sum_valid && sum_last && !clear;

        acc_d = acc_q;
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clear || (sum_valid && sum_last)) begin
            acc_d = '0;
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (sum_valid) begin
            acc_d = add_sum;
            cnt_d = word_cnt;
            sat_d = word_sat;
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        case (out_state_q)
            EMPTY: if (new_result) out_state_d = FULL;
            FULL:  if (!new_result && acc_ready) out_state_d = EMPTY;
            default: out_state_d = EMPTY;
        endcase
    end

    // A full, stalled output keeps its result; the newcomer is dropped and flagged.
    always_comb begin
        load       = new_result && ((out_state_q == EMPTY) || acc_ready);
        res_d      = load ? add_sum  : res_q;
        words_d    = load ? word_cnt : words_q;
        res_sat_d  = load ? word_sat : res_sat_q;
        overflow_d = clear ? 1'b0
                   : (overflow_q | (new_result && (out_state_q == FULL) && !acc_ready));
    end

    always_comb begin
        acc_valid = (out_state_q == FULL);
        acc_out   = res_q;
        acc_words = words_q;
        acc_sat   = res_sat_q;
        overflow  = overflow_q;
    end

endmodule
